// File: rtl/gin_multicast.sv
// Global input network: multicasts one GLB word to every PE whose scan-loaded
// (row ID, column ID) matches the word's tag. Upstream is held until all targets accept.
module gin_multicast #(
    parameter int NUM_ROW  = 6,
    parameter int NUM_COL  = 8,
    parameter int XID_BITS = 5,
    parameter int YID_BITS = 3,
    parameter int DATA_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         set_XID,
    input  logic [XID_BITS-1:0]          XID_scan_in,
    input  logic                         set_YID,
    input  logic [YID_BITS-1:0]          YID_scan_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [XID_BITS-1:0]          in_tag_X,
    input  logic [YID_BITS-1:0]          in_tag_Y,
    output logic [NUM_ROW*NUM_COL-1:0]   pe_valid,
    input  logic [NUM_ROW*NUM_COL-1:0]   pe_ready,
    output logic [DATA_W-1:0]            pe_data,
    output logic                         busy,
    output logic [15:0]                  drop_cnt
);

    localparam int N = NUM_ROW * NUM_COL;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_DELIVER = 1'b1;

    localparam logic [XID_BITS-1:0] X_RSV = '1;
    localparam logic [YID_BITS-1:0] Y_RSV = '1;

    logic [0:0]                        state_q, state_d;
    logic [N-1:0]                      pend_q, pend_d;
    logic [DATA_W-1:0]                 dbuf_q, dbuf_d;
    logic [15:0]                       drop_q, drop_d;
    logic [NUM_ROW-1:0][YID_BITS-1:0]  yid_q, yid_d;
    logic [N-1:0][XID_BITS-1:0]        xid_q, xid_d;

    logic [N-1:0] match;
    logic [N-1:0] rem;
    logic         free;
    logic         accept;

    // Match always uses the IDs as registered, never the value being shifted in.
    always_comb begin
        match = '0;
        if (in_tag_X != X_RSV && in_tag_Y != Y_RSV) begin
            for (int r = 0; r < NUM_ROW; r++) begin
                for (int c = 0; c < NUM_COL; c++) begin
                    match[r*NUM_COL+c] = (yid_q[r] == in_tag_Y) &&
                                         (xid_q[r*NUM_COL+c] == in_tag_X);
                end
            end
        end
    end

    assign rem      = pend_q & ~pe_ready;
    assign free     = (state_q == S_IDLE) || (rem == '0);
    assign in_ready = rst & free;
    assign accept   = in_valid & in_ready;

    assign pe_valid = pend_q;
    assign pe_data  = dbuf_q;
    assign busy     = (state_q == S_DELIVER);
    assign drop_cnt = drop_q;

    always_comb begin
        // NOTE: every *_d gets a default before any branch so no latch is inferred.
        state_d = state_q;
        pend_d  = rem;
        dbuf_d  = dbuf_q;
        drop_d  = drop_q;
        if (free) begin
            state_d = S_IDLE;
            pend_d  = '0;
            if (accept) begin
                dbuf_d = in_data;
                if (match == '0) begin
                    if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                end else begin
                    pend_d  = match;
                    state_d = S_DELIVER;
                end
            end
        end
    end

    always_comb begin
        yid_d = yid_q;
        xid_d = xid_q;
        if (set_YID) begin
            yid_d[0] = YID_scan_in;
            for (int k = 1; k < NUM_ROW; k++) yid_d[k] = yid_q[k-1];
        end
        if (set_XID) begin
            xid_d[0] = XID_scan_in;
            for (int i = 1; i < N; i++) xid_d[i] = xid_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            dbuf_q  <= '0;
            drop_q  <= '0;
            // NOTE: the ID chains are reset because all-ones is the functional "unassigned" ID.
            yid_q   <= '1;
            xid_q   <= '1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
            pend_q  <= pend_d;
            dbuf_q  <= dbuf_d;
            drop_q  <= drop_d;
            yid_q   <= yid_d;
            xid_q   <= xid_d;
        end
    end

endmodule

// File: tb/tb_gin_multicast.sv
// Bench for gin_multicast: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of the multicast network.
module tb_gin_multicast;

    localparam int NUM_ROW  = 6;
    localparam int NUM_COL  = 8;
    localparam int XID_BITS = 5;
    localparam int YID_BITS = 3;
    localparam int DATA_W   = 32;
    localparam int N        = NUM_ROW * NUM_COL;
    localparam int X_ALL    = (1 << XID_BITS) - 1;
    localparam int Y_ALL    = (1 << YID_BITS) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                set_XID, set_YID;
    logic [XID_BITS-1:0] XID_scan_in;
    logic [YID_BITS-1:0] YID_scan_in;
    logic                in_valid, in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [XID_BITS-1:0] in_tag_X;
    logic [YID_BITS-1:0] in_tag_Y;
    logic [N-1:0]        pe_valid, pe_ready;
    logic [DATA_W-1:0]   pe_data;
    logic                busy;
    logic [15:0]         drop_cnt;

    gin_multicast #(
        .NUM_ROW(NUM_ROW), .NUM_COL(NUM_COL), .XID_BITS(XID_BITS),
        .YID_BITS(YID_BITS), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst),
        .set_XID(set_XID), .XID_scan_in(XID_scan_in),
        .set_YID(set_YID), .YID_scan_in(YID_scan_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_tag_X(in_tag_X), .in_tag_Y(in_tag_Y),
        .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_data(pe_data),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: ID tables, the set of PEs still owed the current word, that word, drop count.
    int           m_yid[NUM_ROW];
    int           m_xid[N];
    logic [N-1:0] m_pend;
    logic [31:0]  m_data;
    int           m_drop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_yid[k]) m_yid[k] = Y_ALL;
        foreach (m_xid[i]) m_xid[i] = X_ALL;
        m_pend = '0;
        m_data = '0;
        m_drop = 0;
    endtask

    function automatic logic [N-1:0] model_match(input int tx, input int ty);
        logic [N-1:0] m;
        m = '0;
        if (tx == X_ALL || ty == Y_ALL) return m;
        for (int r = 0; r < NUM_ROW; r++)
            for (int c = 0; c < NUM_COL; c++)
                if (m_yid[r] == ty && m_xid[r*NUM_COL+c] == tx) m[r*NUM_COL+c] = 1'b1;
        return m;
    endfunction

    // One clock: compare outputs at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        logic [N-1:0] owed_after;
        logic [N-1:0] targets;
        logic         can_take;
        @(negedge clk);
        owed_after = m_pend & ~pe_ready;
        can_take   = rst && (owed_after == '0);
        check("in_ready", 64'(in_ready), 64'(can_take));
        check("pe_valid", 64'(pe_valid), 64'(m_pend));
        check("busy", 64'(busy), 64'(m_pend != '0));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (m_pend != '0) check("pe_data", 64'(pe_data), 64'(m_data));
        @(posedge clk);
        if (rst) begin
            targets = model_match(int'(in_tag_X), int'(in_tag_Y));
            m_pend  = owed_after;
            if (in_valid && can_take) begin
                m_data = in_data;
                if (targets == '0) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    m_pend = targets;
                end
            end
            if (set_YID) begin
                for (int k = NUM_ROW - 1; k > 0; k--) m_yid[k] = m_yid[k-1];
                m_yid[0] = int'(YID_scan_in);
            end
            if (set_XID) begin
                for (int i = N - 1; i > 0; i--) m_xid[i] = m_xid[i-1];
                m_xid[0] = int'(XID_scan_in);
            end
        end
        #1;
    endtask

    task automatic load_y(input int want[NUM_ROW]);
        set_YID = 1'b1;
        for (int k = 0; k < NUM_ROW; k++) begin
            YID_scan_in = YID_BITS'(want[NUM_ROW-1-k]);
            cycle();
        end
        set_YID = 1'b0;
    endtask

    task automatic load_x_mod8();
        set_XID = 1'b1;
        for (int i = 0; i < N; i++) begin
            XID_scan_in = XID_BITS'((N - 1 - i) % 8);
            cycle();
        end
        set_XID = 1'b0;
    endtask

    task automatic present(input int tx, input int ty, input logic [31:0] d);
        in_valid = 1'b1;
        in_tag_X = XID_BITS'(tx);
        in_tag_Y = YID_BITS'(ty);
        in_data  = d;
    endtask

    initial begin
        logic [63:0] r64;
        int          d0;
        rst = 1'b0; set_XID = 1'b0; set_YID = 1'b0;
        XID_scan_in = '0; YID_scan_in = '0;
        in_valid = 1'b0; in_data = '0; in_tag_X = '0; in_tag_Y = '0;
        pe_ready = '0;
        model_reset();

        // Reset state and release
        repeat (2) cycle();
        rst = 1'b1;
        #1;
        check("ready_after_release", 64'(in_ready), 64'(1));

        // Reserved row tag under reset IDs drops
        pe_ready = '1;
        present(0, 7, 32'h1111_0000);
        cycle();
        in_valid = 1'b0;

        // ID load and single-PE delivery
        load_y('{0, 1, 2, 3, 4, 5});
        load_x_mod8();
        present(3, 2, 32'hA5A5_0001);
        cycle();
        in_valid = 1'b0;
        check("single_target", 64'(pe_valid), 64'(1) << 19);
        check("single_data", 64'(pe_data), 64'h0000_0000_A5A5_0001);
        cycle();
        check("single_done", 64'(pe_valid), 64'(0));

        // Reserved column tag drops; two drops total so far
        d0 = m_drop;
        present(31, 2, 32'h2222_0000);
        cycle();
        in_valid = 1'b0;
        cycle();
        check("drops_total", 64'(drop_cnt), 64'(d0 + 1));
        check("drops_two", 64'(drop_cnt), 64'(2));

        // Multicast with staggered PE accepts
        load_y('{0, 0, 0, 7, 7, 7});
        pe_ready = '0;
        present(3, 0, 32'hC0DE_0003);
        cycle();
        in_valid = 1'b0;
        check("mc_targets", 64'(pe_valid), 64'h0000_0000_0008_0808);
        pe_ready[3] = 1'b1;  cycle(); pe_ready = '0; cycle();
        pe_ready[11] = 1'b1; cycle(); pe_ready = '0; cycle();
        check("mc_hold", 64'(in_ready), 64'(0));
        pe_ready[19] = 1'b1; #1;
        check("mc_last_ready", 64'(in_ready), 64'(1));
        cycle();
        pe_ready = '0;
        cycle();

        // Back-to-back to PE 19
        load_y('{0, 1, 2, 3, 4, 5});
        pe_ready = '1;
        for (int k = 0; k < 4; k++) begin
            present(3, 2, 32'hB2B0_0000 + 32'(k));
            #1;
            check("b2b_ready", 64'(in_ready), 64'(1));
            cycle();
        end
        in_valid = 1'b0;
        cycle();

        // Scan shift while a word is waiting
        pe_ready = '0;
        present(3, 2, 32'h5CA9_0000);
        cycle();
        in_valid = 1'b0;
        set_XID = 1'b1; XID_scan_in = 5'd3;
        cycle();
        set_XID = 1'b0;
        cycle();
        check("scan_keeps_mask", 64'(pe_valid), 64'(1) << 19);
        pe_ready[19] = 1'b1;
        cycle();
        pe_ready = '1;
        present(3, 2, 32'h5CA9_0001);
        cycle();
        in_valid = 1'b0;
        check("scan_new_ids", 64'(pe_valid), 64'(1) << 20);
        cycle();

        // Random traffic
        for (int t = 0; t < 2000; t++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_tag_X = ($urandom_range(0, 8) == 8) ? XID_BITS'(X_ALL) : XID_BITS'($urandom_range(0, 7));
            in_tag_Y = YID_BITS'($urandom_range(0, 7));
            in_data  = $urandom;
            r64 = {$urandom, $urandom};
            pe_ready = (t % 50 < 10) ? '1 : r64[N-1:0];
            set_XID = ($urandom_range(0, 19) == 0);
            XID_scan_in = XID_BITS'($urandom_range(0, 7));
            set_YID = ($urandom_range(0, 19) == 0);
            YID_scan_in = YID_BITS'($urandom_range(0, 6));
            cycle();
        end
        in_valid = 1'b0; set_XID = 1'b0; set_YID = 1'b0;
        pe_ready = '1;
        cycle();

        // Reset in the middle of a delivery to PEs 3 and 11
        load_y('{0, 0, 7, 7, 7, 7});
        load_x_mod8();
        pe_ready = '0;
        present(3, 0, 32'hDEAD_0808);
        cycle();
        in_valid = 1'b0;
        cycle();
        check("pend_before_reset", 64'(pe_valid), 64'h0000_0000_0000_0808);
        rst = 1'b0;
        #1;
        check("rst_pe_valid", 64'(pe_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_drop", 64'(drop_cnt), 64'(0));
        model_reset();
        repeat (2) cycle();
        rst = 1'b1;
        #1;
        check("rst_release_ready", 64'(in_ready), 64'(1));
        pe_ready = '1;
        present(0, 0, 32'h0000_0BAD);
        cycle();
        in_valid = 1'b0;
        check("rst_ids_ones", 64'(pe_valid), 64'(0));
        check("rst_drop_one", 64'(drop_cnt), 64'(1));
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gin_multicast.md
Name: gin_multicast

Overview:
- Parametrised global input network (GIN) for the PE array. It distributes ifmap, filter and ipsum words from the GLB to every PE whose scan-loaded (row ID, column ID) pair matches the tag sent with the word.
- Successor to the fixed 6x8 GIN. Array size and ID widths are parameters.
- Upstream ready is a true multicast handshake: a word is held until every addressed PE has taken it. Each PE is released as soon as it accepts, so partial delivery is tracked.
- Unmatched words are counted and dropped.

Parameters:
- NUM_ROW, 6, PE rows.
- NUM_COL, 8, PEs per row.
- XID_BITS, 5, column-ID width.
- YID_BITS, 3, row-ID width.
- DATA_W, 32, payload width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- set_XID  in  1  shift column-ID chain this cycle.
- XID_scan_in  in  XID_BITS  column-ID chain input.
- set_YID  in  1  shift row-ID chain this cycle.
- YID_scan_in  in  YID_BITS  row-ID chain input.
- in_valid  in  1  GLB word valid.
- in_ready  out  1  GIN accepts word.
- in_data  in  DATA_W  GLB payload.
- in_tag_X  in  XID_BITS  destination column tag.
- in_tag_Y  in  YID_BITS  destination row tag.
- pe_valid  out  NUM_ROW*NUM_COL  per-PE valid; bit r*NUM_COL+c is PE (r,c).
- pe_ready  in  NUM_ROW*NUM_COL  per-PE ready.
- pe_data  out  DATA_W  broadcast payload.
- busy  out  1  delivery in progress.
- drop_cnt  out  16  count of accepted words that matched no PE; saturates at 16'hFFFF.

Behaviour:
- ID chains:
  - Row chain YID[0..NUM_ROW-1]. On set_YID: YID[0]<=YID_scan_in, YID[k]<=YID[k-1].
  - Column chain XID[0..NUM_ROW*NUM_COL-1]. On set_XID: XID[0]<=XID_scan_in, XID[i]<=XID[i-1].
  - The first value shifted in ends at the highest index after a full load.
  - Reset: all IDs all-ones.
  - Tag all-ones (X or Y) is reserved and never matches.
- Match:
  - PE i=(r,c) matches when YID[r]==in_tag_Y, XID[i]==in_tag_X, and neither tag is all-ones.
  - Match uses register values before any same-cycle scan shift.
  - Shifting during a delivery does not affect the captured mask.
- State IDLE / DELIVER, with registers pend[N], dbuf[DATA_W].
  - IDLE: in_ready=1, pe_valid=0, busy=0.
  - Accept: on in_valid&in_ready, dbuf<=in_data, mask computed from in_tag_X/in_tag_Y.
    - mask==0: drop_cnt+1 (saturating); stay/return IDLE.
    - Otherwise: pend<=mask, go DELIVER.
  - DELIVER: pe_valid=pend, pe_data=dbuf, busy=1.
    - rem = pend & ~pe_ready.
    - Each cycle: pend<=rem.
    - rem==0 means the last PE is served this cycle; in_ready=1 combinationally the same cycle.
    - Accept on that cycle: load the new word (back-to-back, no bubble).
    - No accept on that cycle: go IDLE.
    - rem!=0: in_ready=0.
- A PE's valid drops the cycle after its pe_ready is seen high. Valid is never reasserted for the same word.
- Latency: word accepted at edge t gives pe_valid/pe_data at t+1. Sustained throughput is 1 word/cycle when all targets are ready.
- pe_data is stable for the whole DELIVER of a word. pe_data equals dbuf in IDLE as well; its value there is don't-care.
- in_ready is independent of in_valid. No combinational path exists from in_valid to any output.
- Reset, including mid-delivery: state=IDLE, pend=0, pe_valid=0, busy=0, drop_cnt=0, IDs all-ones, dbuf=0. in_ready=0 while rst low and 1 from the first cycle after release.
- The in-flight word is lost on reset; this is not reported.

Test Plan:
- ID load: 6 cycles set_YID with 5,4,3,2,1,0 → YID[0..5]=0..5. 48 cycles set_XID with values 47-i mod 8 → XID[i]=i%8. Word tag (X=3,Y=2), data 32'hA5A5_0001, all pe_ready=1 → only pe_valid[19] high for 1 cycle, pe_data=A5A5_0001, drop_cnt stays 0.
- Multicast partial: same IDs, tag X=3 under the row-ID pattern (0,0,0,7,7,7), i.e. rows 0–2 share Y=0 → targets PEs 3,11,19. pe_ready[3]=1 at t+1, [11] at t+3, [19] at t+5 → each valid drops after its accept. in_ready=0 until t+5, busy=1 from t+1 to t+5.
- Back-to-back: 4 words to PE 19, pe_ready tied 1 → accepts on 4 consecutive cycles, pe_valid[19] high 4 consecutive cycles, data in order.
- No match / reserved: tag Y=7 with default reset IDs; then tag X=31 after loading → no pe_valid, drop_cnt=2, in_ready stays 1.
- Scan during delivery: while a word waits on PE 19 (pe_ready=0), pulse set_XID 1 cycle, then raise pe_ready[19] → delivery still completes to PE 19. The next word uses the shifted IDs.
- Reset mid-delivery: assert rst while pend=0x…0808 → pe_valid=0 immediately, in_ready=0 during reset and 1 after release, drop_cnt=0, IDs all-ones (tag 0,0 drops).
